// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding into the ALU and load-use hazard detection.
// Holds the decoded ID fields for one cycle and presents forwarded operands combinationally in EX.
module id_ex_stage #(
   parameter int DATA_W  = 16,
   parameter int RADDR_W = 4,
   parameter int FUNCT_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               id_valid,
   input  logic [FUNCT_W-1:0] id_funct,
   input  logic [RADDR_W-1:0] id_rs1,
   input  logic [RADDR_W-1:0] id_rs2,
   input  logic [RADDR_W-1:0] id_rd,
   input  logic [DATA_W-1:0]  id_rd1,
   input  logic [DATA_W-1:0]  id_rd2,
   input  logic [DATA_W-1:0]  id_imm,
   input  logic               id_use_imm,
   input  logic               id_mem_read,
   input  logic               id_reg_write,
   input  logic               flush,
   input  logic               stall_in,
   input  logic               exm_reg_write,
   input  logic [RADDR_W-1:0] exm_rd,
   input  logic [DATA_W-1:0]  exm_result,
   input  logic               exm_r0_write,
   input  logic [DATA_W-1:0]  exm_r0,
   input  logic               wb_reg_write,
   input  logic [RADDR_W-1:0] wb_rd,
   input  logic [DATA_W-1:0]  wb_data,
   output logic [FUNCT_W-1:0] funct,
   output logic [DATA_W-1:0]  Rout1,
   output logic [DATA_W-1:0]  Rout2,
   output logic               ex_valid,
   output logic               ex_reg_write,
   output logic               ex_mem_read,
   output logic [RADDR_W-1:0] ex_rd,
   output logic               hazard_stall,
   output logic [15:0]        stall_count
);

   logic [RADDR_W-1:0] ex_rs1;
   logic [RADDR_W-1:0] ex_rs2;
   logic [DATA_W-1:0]  ex_rd1;
   logic [DATA_W-1:0]  ex_rd2;
   logic [DATA_W-1:0]  ex_imm;
   logic               ex_use_imm;

   logic rs1_hit;
   logic rs2_hit;
   logic load_bubble;
   logic count_hazard;

   // A load in EX cannot feed the instruction behind it, so ID waits one cycle.
   assign rs1_hit      = (id_rs1 == ex_rd);
   assign rs2_hit      = !id_use_imm && (id_rs2 == ex_rd);
   assign hazard_stall = id_valid && !stall_in && ex_valid && ex_mem_read && (rs1_hit || rs2_hit);

   assign load_bubble  = flush || hazard_stall || !id_valid;
   assign count_hazard = hazard_stall && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid     <= 1'b0;
         funct        <= '0;
         ex_rs1       <= '0;
         ex_rs2       <= '0;
         ex_rd        <= '0;
         ex_rd1       <= '0;
         ex_rd2       <= '0;
         ex_imm       <= '0;
         ex_use_imm   <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         stall_count  <= '0;
      end else if (!stall_in) begin
         if (load_bubble) begin
            ex_valid     <= 1'b0;
            funct        <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_rd1       <= '0;
            ex_rd2       <= '0;
            ex_imm       <= '0;
            ex_use_imm   <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
         end else begin
            ex_valid     <= 1'b1;
            funct        <= id_funct;
            ex_rs1       <= id_rs1;
            ex_rs2       <= id_rs2;
            ex_rd        <= id_rd;
            ex_rd1       <= id_rd1;
            ex_rd2       <= id_rd2;
            ex_imm       <= id_imm;
            ex_use_imm   <= id_use_imm;
            ex_reg_write <= id_reg_write;
            ex_mem_read  <= id_mem_read;
         end
         if (count_hazard && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
         end
      end
   end

   // The mul/div R0 side result is the youngest write to R0, so it outranks the main EX/MEM result.
   always_comb begin
      Rout1 = ex_rd1;
      if (ex_valid) begin
         if (exm_r0_write && (ex_rs1 == '0)) begin
            Rout1 = exm_r0;
         end else if (exm_reg_write && (exm_rd == ex_rs1)) begin
            Rout1 = exm_result;
         end else if (wb_reg_write && (wb_rd == ex_rs1)) begin
            Rout1 = wb_data;
         end
      end
   end

   always_comb begin
      Rout2 = ex_rd2;
      if (ex_use_imm) begin
         Rout2 = ex_imm;
      end else if (ex_valid) begin
         if (exm_r0_write && (ex_rs2 == '0)) begin
            Rout2 = exm_r0;
         end else if (exm_reg_write && (exm_rd == ex_rs2)) begin
            Rout2 = exm_result;
         end else if (wb_reg_write && (wb_rd == ex_rs2)) begin
            Rout2 = wb_data;
         end
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a table of single-instruction vectors with forwarding
// inputs, then hand-written load-use, flush, hold, reset and counter-saturation sequences.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [3:0]  id_funct;
   logic [3:0]  id_rs1, id_rs2, id_rd;
   logic [15:0] id_rd1, id_rd2, id_imm;
   logic        id_use_imm, id_mem_read, id_reg_write;
   logic        flush, stall_in;
   logic        exm_reg_write;
   logic [3:0]  exm_rd;
   logic [15:0] exm_result;
   logic        exm_r0_write;
   logic [15:0] exm_r0;
   logic        wb_reg_write;
   logic [3:0]  wb_rd;
   logic [15:0] wb_data;
   logic [3:0]  funct;
   logic [15:0] Rout1, Rout2;
   logic        ex_valid, ex_reg_write, ex_mem_read;
   logic [3:0]  ex_rd;
   logic        hazard_stall;
   logic [15:0] stall_count;

   int checks   = 0;
   int failures = 0;

   id_ex_stage #(.DATA_W(16), .RADDR_W(4), .FUNCT_W(4)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_funct(id_funct),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
      .id_use_imm(id_use_imm), .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
      .flush(flush), .stall_in(stall_in),
      .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
      .exm_r0_write(exm_r0_write), .exm_r0(exm_r0),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
      .funct(funct), .Rout1(Rout1), .Rout2(Rout2),
      .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_rd(ex_rd), .hazard_stall(hazard_stall), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [3:0]  funct, rs1, rs2, rd;
      logic [15:0] rd1, rd2, imm;
      logic        use_imm, mem_read, reg_write, flush;
   } id_t;

   typedef struct {
      logic        exm_reg_write;
      logic [3:0]  exm_rd;
      logic [15:0] exm_result;
      logic        exm_r0_write;
      logic [15:0] exm_r0;
      logic        wb_reg_write;
      logic [3:0]  wb_rd;
      logic [15:0] wb_data;
   } fwd_t;

   typedef struct {
      logic [3:0]  funct;
      logic [15:0] r1, r2;
      logic        valid;
      logic [3:0]  rd;
   } exp_t;

   typedef struct {
      id_t  id;
      fwd_t fw;
      exp_t ex;
   } vec_t;

   vec_t vecs[11];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic setId(input logic v, input logic [3:0] f, input logic [3:0] r1, input logic [3:0] r2,
                        input logic [3:0] rd, input logic [15:0] d1, input logic [15:0] d2,
                        input logic [15:0] im, input logic ui, input logic mr, input logic rw);
      id_valid     = v;
      id_funct     = f;
      id_rs1       = r1;
      id_rs2       = r2;
      id_rd        = rd;
      id_rd1       = d1;
      id_rd2       = d2;
      id_imm       = im;
      id_use_imm   = ui;
      id_mem_read  = mr;
      id_reg_write = rw;
   endtask

   task automatic setFwd(input fwd_t fw);
      exm_reg_write = fw.exm_reg_write;
      exm_rd        = fw.exm_rd;
      exm_result    = fw.exm_result;
      exm_r0_write  = fw.exm_r0_write;
      exm_r0        = fw.exm_r0;
      wb_reg_write  = fw.wb_reg_write;
      wb_rd         = fw.wb_rd;
      wb_data       = fw.wb_data;
   endtask

   task automatic clearFwd();
      fwd_t z;
      z = '{1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 1'b0, 4'd0, 16'h0};
      setFwd(z);
   endtask

   task automatic applyStimulus(input vec_t v);
      setId(v.id.valid, v.id.funct, v.id.rs1, v.id.rs2, v.id.rd, v.id.rd1, v.id.rd2,
            v.id.imm, v.id.use_imm, v.id.mem_read, v.id.reg_write);
      flush    = v.id.flush;
      stall_in = 1'b0;
      clearFwd();
      tick();
      setFwd(v.fw);
      #1;
   endtask

   initial begin
      vecs[0]  = '{'{1'b1, 4'hF, 4'd1, 4'd2, 4'd3, 16'h1111, 16'h2222, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0},
                   '{1'b0, 4'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0, 16'h0000},
                   '{4'hF, 16'h1111, 16'h2222, 1'b1, 4'd3}};
      vecs[1]  = '{'{1'b1, 4'h2, 4'd3, 4'd5, 4'd4, 16'h0100, 16'h0200, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0},
                   '{1'b1, 4'd3, 16'h0007, 1'b0, 16'h0000, 1'b1, 4'd3, 16'h0009},
                   '{4'h2, 16'h0007, 16'h0200, 1'b1, 4'd4}};
      vecs[2]  = '{'{1'b1, 4'h2, 4'd3, 4'd5, 4'd4, 16'h0100, 16'h0200, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0},
                   '{1'b0, 4'd3, 16'h0007, 1'b0, 16'h0000, 1'b1, 4'd3, 16'h0009},
                   '{4'h2, 16'h0009, 16'h0200, 1'b1, 4'd4}};
      vecs[3]  = '{'{1'b1, 4'h4, 4'd6, 4'd6, 4'd1, 16'h0001, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0},
                   '{1'b0, 4'd0, 16'h0000, 1'b0, 16'h0000, 1'b1, 4'd6, 16'h1234},
                   '{4'h4, 16'h1234, 16'h1234, 1'b1, 4'd1}};
      vecs[4]  = '{'{1'b1, 4'h6, 4'd2, 4'd0, 4'd5, 16'h0222, 16'h0333, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0},
                   '{1'b1, 4'd0, 16'h0005, 1'b1, 16'h0014, 1'b0, 4'd0, 16'h0000},
                   '{4'h6, 16'h0222, 16'h0014, 1'b1, 4'd5}};
      vecs[5]  = '{'{1'b1, 4'h6, 4'd2, 4'd0, 4'd5, 16'h0222, 16'h0333, 16'hFFFB, 1'b1, 1'b0, 1'b1, 1'b0},
                   '{1'b1, 4'd0, 16'h0005, 1'b1, 16'h0014, 1'b0, 4'd0, 16'h0000},
                   '{4'h6, 16'h0222, 16'hFFFB, 1'b1, 4'd5}};
      vecs[6]  = '{'{1'b1, 4'h7, 4'd0, 4'd9, 4'd2, 16'h0777, 16'h0888, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0},
                   '{1'b1, 4'd0, 16'h0005, 1'b0, 16'h0000, 1'b0, 4'd0, 16'h0000},
                   '{4'h7, 16'h0005, 16'h0888, 1'b1, 4'd2}};
      vecs[7]  = '{'{1'b0, 4'hF, 4'd0, 4'd0, 4'd3, 16'h5555, 16'h6666, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0},
                   '{1'b1, 4'd0, 16'h0005, 1'b1, 16'h0014, 1'b1, 4'd0, 16'h0099},
                   '{4'h0, 16'h0000, 16'h0000, 1'b0, 4'd0}};
      vecs[8]  = '{'{1'b1, 4'h9, 4'd1, 4'd2, 4'd3, 16'h1357, 16'h2468, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1},
                   '{1'b0, 4'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'd0, 16'h0000},
                   '{4'h0, 16'h0000, 16'h0000, 1'b0, 4'd0}};
      vecs[9]  = '{'{1'b1, 4'h3, 4'd7, 4'd8, 4'd10, 16'h0707, 16'h0808, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0},
                   '{1'b1, 4'd8, 16'hABCD, 1'b0, 16'h0000, 1'b1, 4'd8, 16'h1111},
                   '{4'h3, 16'h0707, 16'hABCD, 1'b1, 4'd10}};
      vecs[10] = '{'{1'b1, 4'h1, 4'd0, 4'd0, 4'd4, 16'h0011, 16'h0022, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0},
                   '{1'b1, 4'd0, 16'h0005, 1'b1, 16'h0042, 1'b1, 4'd0, 16'h0009},
                   '{4'h1, 16'h0042, 16'h0042, 1'b1, 4'd4}};

      rst = 1'b1;
      flush = 1'b0;
      stall_in = 1'b0;
      setId(1'b0, 4'h0, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      clearFwd();
      #12;
      checkOutput("reset.funct", 32'(funct), 32'h0);
      checkOutput("reset.ex_valid", 32'(ex_valid), 32'h0);
      checkOutput("reset.ex_reg_write", 32'(ex_reg_write), 32'h0);
      checkOutput("reset.ex_mem_read", 32'(ex_mem_read), 32'h0);
      checkOutput("reset.stall_count", 32'(stall_count), 32'h0);
      checkOutput("reset.Rout1", 32'(Rout1), 32'h0);
      checkOutput("reset.Rout2", 32'(Rout2), 32'h0);
      checkOutput("reset.hazard", 32'(hazard_stall), 32'h0);
      #1 rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("v%0d.funct", i), 32'(funct), 32'(vecs[i].ex.funct));
         checkOutput($sformatf("v%0d.Rout1", i), 32'(Rout1), 32'(vecs[i].ex.r1));
         checkOutput($sformatf("v%0d.Rout2", i), 32'(Rout2), 32'(vecs[i].ex.r2));
         checkOutput($sformatf("v%0d.ex_valid", i), 32'(ex_valid), 32'(vecs[i].ex.valid));
         checkOutput($sformatf("v%0d.ex_rd", i), 32'(ex_rd), 32'(vecs[i].ex.rd));
         checkOutput($sformatf("v%0d.hazard", i), 32'(hazard_stall), 32'h0);
      end
      clearFwd();
      flush = 1'b0;

      // Load-use: one bubble, then the dependent add enters EX with the load data from WB.
      setId(1'b1, 4'h1, 4'd1, 4'd0, 4'd4, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
      tick();
      setId(1'b1, 4'hF, 4'd4, 4'd5, 4'd6, 16'h0000, 16'h0003, 16'h0000, 1'b0, 1'b0, 1'b1);
      #1;
      checkOutput("lu.hazard", 32'(hazard_stall), 32'h1);
      checkOutput("lu.ex_mem_read", 32'(ex_mem_read), 32'h1);
      tick();
      checkOutput("lu.bubble_valid", 32'(ex_valid), 32'h0);
      checkOutput("lu.bubble_funct", 32'(funct), 32'h0);
      checkOutput("lu.count1", 32'(stall_count), 32'h1);
      checkOutput("lu.hazard_clear", 32'(hazard_stall), 32'h0);
      tick();
      wb_reg_write = 1'b1;
      wb_rd = 4'd4;
      wb_data = 16'h0055;
      #1;
      checkOutput("lu.enter_valid", 32'(ex_valid), 32'h1);
      checkOutput("lu.enter_funct", 32'(funct), 32'hF);
      checkOutput("lu.enter_rd", 32'(ex_rd), 32'h6);
      checkOutput("lu.Rout1_wb", 32'(Rout1), 32'h0055);
      checkOutput("lu.Rout2", 32'(Rout2), 32'h0003);
      checkOutput("lu.count_still1", 32'(stall_count), 32'h1);
      clearFwd();

      // rs2 match is ignored with an immediate; stall_in masks the hazard; flush wins over it.
      setId(1'b1, 4'h1, 4'd1, 4'd0, 4'd4, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
      tick();
      setId(1'b1, 4'hF, 4'd1, 4'd4, 4'd6, 16'h0000, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b1);
      #1;
      checkOutput("hz.imm_masks_rs2", 32'(hazard_stall), 32'h0);
      id_use_imm = 1'b0;
      #1;
      checkOutput("hz.rs2_match", 32'(hazard_stall), 32'h1);
      stall_in = 1'b1;
      #1;
      checkOutput("hz.stall_in_masks", 32'(hazard_stall), 32'h0);
      stall_in = 1'b0;
      flush = 1'b1;
      #1;
      checkOutput("hz.with_flush", 32'(hazard_stall), 32'h1);
      tick();
      checkOutput("hz.flush_bubble", 32'(ex_valid), 32'h0);
      checkOutput("hz.flush_funct", 32'(funct), 32'h0);
      checkOutput("hz.flush_no_count", 32'(stall_count), 32'h1);
      flush = 1'b0;

      // stall_in holds EX even when flush is also raised.
      setId(1'b1, 4'h5, 4'd2, 4'd3, 4'd7, 16'h0ABC, 16'h0DEF, 16'h0000, 1'b0, 1'b0, 1'b1);
      tick();
      setId(1'b1, 4'h9, 4'd8, 4'd9, 4'd9, 16'h1111, 16'h2222, 16'h0000, 1'b0, 1'b0, 1'b1);
      flush = 1'b1;
      stall_in = 1'b1;
      tick();
      checkOutput("hold.funct", 32'(funct), 32'h5);
      checkOutput("hold.ex_valid", 32'(ex_valid), 32'h1);
      checkOutput("hold.ex_rd", 32'(ex_rd), 32'h7);
      checkOutput("hold.Rout1", 32'(Rout1), 32'h0ABC);
      flush = 1'b0;
      stall_in = 1'b0;

      // Reset in the middle of a load-use stall, then an add straight after release.
      setId(1'b1, 4'h1, 4'd1, 4'd0, 4'd4, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
      tick();
      setId(1'b1, 4'hF, 4'd4, 4'd5, 4'd6, 16'h0000, 16'h0003, 16'h0000, 1'b0, 1'b0, 1'b1);
      #1;
      checkOutput("rst.hazard_before", 32'(hazard_stall), 32'h1);
      rst = 1'b1;
      #1;
      checkOutput("rst.hazard", 32'(hazard_stall), 32'h0);
      checkOutput("rst.ex_valid", 32'(ex_valid), 32'h0);
      checkOutput("rst.ex_mem_read", 32'(ex_mem_read), 32'h0);
      checkOutput("rst.funct", 32'(funct), 32'h0);
      checkOutput("rst.stall_count", 32'(stall_count), 32'h0);
      checkOutput("rst.Rout1", 32'(Rout1), 32'h0);
      setId(1'b1, 4'hF, 4'd1, 4'd2, 4'd3, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b0, 1'b0, 1'b1);
      rst = 1'b0;
      tick();
      checkOutput("rst.add_funct", 32'(funct), 32'hF);
      checkOutput("rst.add_Rout1", 32'(Rout1), 32'hAAAA);
      checkOutput("rst.add_Rout2", 32'(Rout2), 32'hAAAA);
      checkOutput("rst.add_valid", 32'(ex_valid), 32'h1);

      // Self-dependent load alternates capture and bubble, one hazard every two cycles.
      rst = 1'b1;
      #1 rst = 1'b0;
      setId(1'b1, 4'h1, 4'd4, 4'd4, 4'd4, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
      repeat (131068) @(posedge clk);
      #1;
      checkOutput("sat.count_fffe", 32'(stall_count), 32'hFFFE);
      checkOutput("sat.bubble", 32'(ex_valid), 32'h0);
      tick();
      checkOutput("sat.hazard1", 32'(hazard_stall), 32'h1);
      tick();
      checkOutput("sat.count_ffff", 32'(stall_count), 32'hFFFF);
      tick();
      checkOutput("sat.hazard2", 32'(hazard_stall), 32'h1);
      tick();
      checkOutput("sat.count_held", 32'(stall_count), 32'hFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
